// File: rtl/heartbeat_pkg.sv
// Shared types and default constants for the heartbeat monitor.
package heartbeat_pkg;

  // Default counter width; covers the default timeout.
  localparam int unsigned CntWDef       = 26;
  // Default silence, in clk_i cycles, before the source is declared lost.
  localparam int unsigned TimeoutCycDef = 33_554_432;
  // Default number of regular edges needed to declare the source alive.
  localparam int unsigned LockEdgesDef  = 4;

  typedef enum logic [1:0] {
    StLost  = 2'd0,
    StAcq   = 2'd1,
    StAlive = 2'd2
  } hb_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level, plus a delay flop so that
// every change of the synchronised level (rising or falling) yields a
// one-cycle edge strobe.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);

  logic [1:0] sync_q;
  logic       dly_q;

  // Synchroniser chain and edge-detect delay flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_i};
      dly_q  <= sync_q[1];
    end
  end

  assign edge_o = sync_q[1] ^ dly_q;

endmodule

// File: rtl/heartbeat_monitor.sv
// Heartbeat monitor: measures the interval between heartbeat edges, declares
// the source alive after a run of regular edges and lost after a silence.
module heartbeat_monitor
  import heartbeat_pkg::*;
#(
  parameter int unsigned CNT_W       = CntWDef,
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDef,
  parameter int unsigned LOCK_EDGES  = LockEdgesDef
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hb_i,
  output logic             alive_o,
  output logic             lost_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_vld_o
);

  // Edge counter must be able to hold LOCK_EDGES itself.
  localparam int unsigned EcW = $clog2(LOCK_EDGES + 1);

  localparam logic [CNT_W-1:0] GapMax  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] GapLast = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [EcW-1:0]   LockCnt = EcW'(LOCK_EDGES);

  logic             hb_edge;
  logic             timeout;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [EcW-1:0]   edge_cnt_q, edge_cnt_d;
  logic [EcW-1:0]   edge_cnt_inc;
  hb_state_t        state_q, state_d;
  logic             alive_q, alive_d;
  logic             lost_q, lost_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] period_q, period_d;

  sync_edge_det u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (hb_i),
    .edge_o  (hb_edge)
  );

  // An edge in the same cycle as the last silent cycle wins over the timeout.
  assign timeout      = (gap_q == GapLast) && !hb_edge;
  assign edge_cnt_inc = edge_cnt_q + EcW'(1);

  // Gap counter: cleared by an edge, otherwise counts up and saturates.
  always_comb begin
    gap_d = gap_q;
    if (hb_edge) begin
      gap_d = '0;
    end else if (gap_q != GapMax) begin
      gap_d = gap_q + CNT_W'(1);
    end
  end

  // State, edge count and gap registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StLost;
      edge_cnt_q <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      gap_q      <= gap_d;
    end
  end

  // Next-state logic and edge counting.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    unique case (state_q)
      StLost: begin
        if (hb_edge) begin
          state_d    = StAcq;
          edge_cnt_d = EcW'(1);
        end
      end
      StAcq: begin
        if (hb_edge) begin
          if (edge_cnt_q < LockCnt) begin
            edge_cnt_d = edge_cnt_inc;
          end
          if (edge_cnt_inc >= LockCnt) begin
            state_d = StAlive;
          end
        end else if (timeout) begin
          state_d    = StLost;
          edge_cnt_d = '0;
        end
      end
      StAlive: begin
        if (hb_edge) begin
          if (edge_cnt_q < LockCnt) begin
            edge_cnt_d = edge_cnt_inc;
          end
        end else if (timeout) begin
          state_d    = StLost;
          edge_cnt_d = '0;
        end
      end
      default: begin
        state_d    = StLost;
        edge_cnt_d = '0;
      end
    endcase
  end

  // Output next values; the first edge after LOST has no valid start, so no period.
  always_comb begin
    period_d = period_q;
    vld_d    = 1'b0;
    lost_d   = 1'b0;
    alive_d  = (state_d == StAlive);
    if (hb_edge && (state_q != StLost)) begin
      period_d = gap_q + CNT_W'(1);
      vld_d    = 1'b1;
    end
    if ((state_q == StAlive) && timeout) begin
      lost_d = 1'b1;
    end
  end

  // Output registers; period holds through LOST and clears only on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alive_q  <= 1'b0;
      lost_q   <= 1'b0;
      vld_q    <= 1'b0;
      period_q <= '0;
    end else begin
      alive_q  <= alive_d;
      lost_q   <= lost_d;
      vld_q    <= vld_d;
      period_q <= period_d;
    end
  end

  assign alive_o      = alive_q;
  assign lost_o       = lost_q;
  assign period_vld_o = vld_q;
  assign period_o     = period_q;

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Directed bench for heartbeat_monitor with TIMEOUT_CYC = 1000, LOCK_EDGES = 4.
// Each table record sets rst/hb, advances a number of cycles, then checks outputs.
module tb_heartbeat_monitor;

  localparam int unsigned CntW = 26;

  logic            clk = 1'b0;
  logic            rst;
  logic            hb;
  logic            alive;
  logic            lost;
  logic            vld;
  logic [CntW-1:0] period;

  typedef struct {
    logic            rst;
    logic            hb;
    int unsigned     ncyc;
    logic            alive;
    logic            lost;
    logic            vld;
    logic [CntW-1:0] period;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   lost_cnt = 0;

  always #5 clk = ~clk;

  heartbeat_monitor #(
    .CNT_W       (CntW),
    .TIMEOUT_CYC (1000),
    .LOCK_EDGES  (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .hb_i         (hb),
    .alive_o      (alive),
    .lost_o       (lost),
    .period_o     (period),
    .period_vld_o (vld)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (lost === 1'b1) lost_cnt++;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic h, input int unsigned n, input logic a,
                     input logic l, input logic v, input int unsigned p);
    vec_t e;
    e.rst    = r;
    e.hb     = h;
    e.ncyc   = n;
    e.alive  = a;
    e.lost   = l;
    e.vld    = v;
    e.period = CntW'(p);
    vecs.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    hb  = 1'b0;

    // Reset held 5 cycles with hb toggling: everything stays 0.
    add(1, 1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0);
    // Release with hb high: first edge enters ACQ, no period.
    add(0, 1, 3,   0, 0, 0, 0);
    add(0, 1, 97,  0, 0, 0, 0);
    add(0, 0, 3,   0, 0, 1, 100);
    add(0, 0, 1,   0, 0, 0, 100);
    add(0, 0, 96,  0, 0, 0, 100);
    add(0, 1, 3,   0, 0, 1, 100);
    add(0, 1, 97,  0, 0, 0, 100);
    add(0, 0, 3,   1, 0, 1, 100);  // 4th change: alive
    add(0, 0, 1,   1, 0, 0, 100);
    add(0, 0, 96,  1, 0, 0, 100);
    // Silence: loss exactly 1000 cycles after the last edge.
    add(0, 0, 902, 1, 0, 0, 100);
    add(0, 0, 1,   0, 1, 0, 100);
    add(0, 0, 1,   0, 0, 0, 100);
    // Failed acquire: 2 edges then silence, back to LOST quietly.
    add(0, 1, 3,    0, 0, 0, 100);
    add(0, 1, 97,   0, 0, 0, 100);
    add(0, 0, 3,    0, 0, 1, 100);
    add(0, 0, 1,    0, 0, 0, 100);
    add(0, 0, 1100, 0, 0, 0, 100);
    add(0, 1, 3,    0, 0, 0, 100);  // no period: proves LOST, not ACQ
    // Relock.
    add(0, 1, 97,  0, 0, 0, 100);
    add(0, 0, 3,   0, 0, 1, 100);
    add(0, 0, 97,  0, 0, 0, 100);
    add(0, 1, 3,   0, 0, 1, 100);
    add(0, 1, 97,  0, 0, 0, 100);
    add(0, 0, 3,   1, 0, 1, 100);
    // Boundary: edge when gap = 999 keeps alive, period 1000.
    add(0, 0, 997, 1, 0, 0, 100);
    add(0, 1, 3,   1, 0, 1, 1000);
    // Next edge one cycle late: loss first, then the edge starts acquisition.
    add(0, 1, 998, 1, 0, 0, 1000);
    add(0, 0, 2,   0, 1, 0, 1000);
    add(0, 0, 1,   0, 0, 0, 1000);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      hb  = vecs[i].hb;
      ticks(vecs[i].ncyc);
      check("alive",  i, {31'b0, alive}, {31'b0, vecs[i].alive});
      check("lost",   i, {31'b0, lost},  {31'b0, vecs[i].lost});
      check("vld",    i, {31'b0, vld},   {31'b0, vecs[i].vld});
      check("period", i, {6'b0, period}, {6'b0, vecs[i].period});
    end
    check("lost_pulses_table", -1, lost_cnt, 2);

    // Relock toward a reset in ALIVE with gap = 500.
    ticks(97);
    repeat (3) begin
      hb = ~hb;
      ticks(100);
    end
    check("relock_alive", -1, {31'b0, alive}, 32'd1);
    ticks(403);
    rst = 1'b1;
    tick();
    check("midrst_alive",  -1, {31'b0, alive}, 32'd0);
    check("midrst_period", -1, {6'b0, period}, 32'd0);
    check("midrst_vld",    -1, {31'b0, vld},   32'd0);
    check("midrst_lost",   -1, {31'b0, lost},  32'd0);
    tick();
    // Release with hb high counts as the first edge.
    rst = 1'b0;
    ticks(100);
    hb = ~hb;
    ticks(3);
    check("rst_period_vld", -1, {31'b0, vld},   32'd1);
    check("rst_period",     -1, {6'b0, period}, 32'd100);
    check("rst_alive_early", -1, {31'b0, alive}, 32'd0);
    ticks(97);
    hb = ~hb;
    ticks(100);
    hb = ~hb;
    ticks(2);
    check("rst_alive_before", -1, {31'b0, alive}, 32'd0);
    tick();
    check("rst_alive_after", -1, {31'b0, alive}, 32'd1);
    check("rst_lock_vld",    -1, {31'b0, vld},   32'd1);
    check("rst_lock_period", -1, {6'b0, period}, 32'd100);
    check("lost_pulses_total", -1, lost_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
